// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the line-wide data memory.
// Define ARB_TIMEOUT_EN to abort stalled BUSY transactions after TIMEOUT cycles and flag err.
module dmem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data,
  input  logic          mem_done,
  output logic          err
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e state_q;
  logic   last_grant_q;
  logic   owner_q;
  logic   we_q;

  // Arbitration: a single requester wins outright, a tie goes to the one not served last.
  logic          pick_valid;
  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    pick_valid = req0 | req1;
    pick       = 1'b0;
    if (req0 && req1) begin
      pick = ~last_grant_q;
    end else if (req1) begin
      pick = 1'b1;
    end
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  logic tmo_hit;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  assign tmo_hit = (state_q == StBusy) && (tmo_cnt_q == 16'(TIMEOUT - 1));

  // Counter sits at zero outside BUSY, so it is already cleared on BUSY entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err       <= 1'b0;
    end else if (state_q != StBusy) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
      if (tmo_hit && !mem_done) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      grant          <= 2'b00;
      busy           <= 1'b0;
      rdata          <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            owner_q        <= pick;
            we_q           <= sel_we;
            mem_address    <= sel_addr;
            mem_write_data <= sel_wdata;
            mem_read       <= ~sel_we;
            mem_write      <= sel_we;
            grant          <= pick ? 2'b10 : 2'b01;
            busy           <= 1'b1;
            state_q        <= StBusy;
          end
        end
        StBusy: begin
          // A timeout completes like a normal transfer but never updates rdata.
          if (mem_done || tmo_hit) begin
            if (mem_done && !we_q) begin
              rdata <= mem_read_data;
            end
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            done0        <= ~owner_q;
            done1        <= owner_q;
            last_grant_q <= owner_q;
            state_q      <= StResp;
          end
        end
        StResp: begin
          grant   <= 2'b00;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_timeout_range: assert property (@(posedge clk) (TIMEOUT >= 2) && (TIMEOUT <= 65536));
  a_enables_excl: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_done_in_resp: assert property (@(posedge clk) disable iff (reset)
                                   (done0 || done1) |-> (state_q == StResp));
  a_resp_quiet: assert property (@(posedge clk) disable iff (reset)
                                 (state_q == StResp) |-> !(mem_read || mem_write));
  a_busy_state: assert property (@(posedge clk) disable iff (reset)
                                 busy == (state_q != StIdle));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; the memory side is driven by hand.
module tb_dmem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, busy, mem_read, mem_write, mem_done, err;
  logic [DW-1:0] rdata, mem_write_data, mem_read_data;
  logic [1:0]    grant;
  logic [AW-1:0] mem_address;

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] RdLine  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] WrLine  = {16{8'hA5}};
  localparam logic [DW-1:0] RdLine2 = 128'hFEDCBA98765432100011223344556677;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_done(mem_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first BUSY cycle; raises mem_done in BUSY cycle `lat`, returns in RESP.
  task automatic xact(input int lat, input logic [DW-1:0] rd, output int rd_cyc,
                      output int wr_cyc);
    rd_cyc = 0;
    wr_cyc = 0;
    for (int i = 1; i <= lat; i++) begin
      check("excl", DW'(mem_read & mem_write), '0);
      if (mem_read) rd_cyc++;
      if (mem_write) wr_cyc++;
      if (i == lat) begin
        mem_done      = 1'b1;
        mem_read_data = rd;
      end
      tick();
      mem_done = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc, wc, n;
    logic [1:0] exp_g;
    reset = 1'b1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; mem_done = 0; mem_read_data = '0;
    #1;
    do_reset(2);
    check("rst_grant", DW'(grant), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'({done1, done0}), '0);
    check("rst_en", DW'({mem_read, mem_write}), '0);
    check("rst_addr", DW'(mem_address), '0);
    check("rst_wdata", mem_write_data, '0);
    check("rst_rdata", rdata, '0);
    check("rst_err", DW'(err), '0);

    // Read by requester 0.
    req0 = 1; we0 = 0; addr0 = 32'h40;
    tick();
    check("rd_grant", DW'(grant), DW'(2'b01));
    check("rd_busy", DW'(busy), 1);
    check("rd_addr", DW'(mem_address), DW'(32'h40));
    xact(3, RdLine, rc, wc);
    check("rd_rcyc", DW'(rc), 3);
    check("rd_wcyc", DW'(wc), 0);
    check("rd_done0", DW'(done0), 1);
    check("rd_done1", DW'(done1), 0);
    check("rd_rdata", rdata, RdLine);
    check("rd_resp_en", DW'({mem_read, mem_write}), '0);
    check("rd_resp_grant", DW'(grant), DW'(2'b01));
    req0 = 0;
    tick();
    check("rd_done_pulse", DW'(done0), 0);
    check("rd_idle_grant", DW'(grant), '0);
    check("rd_idle_busy", DW'(busy), 0);

    // Write by requester 1.
    req1 = 1; we1 = 1; addr1 = 32'h80; wdata1 = WrLine;
    tick();
    check("wr_grant", DW'(grant), DW'(2'b10));
    check("wr_addr", DW'(mem_address), DW'(32'h80));
    check("wr_wdata", mem_write_data, WrLine);
    xact(2, RdLine2, rc, wc);
    check("wr_rcyc", DW'(rc), 0);
    check("wr_wcyc", DW'(wc), 2);
    check("wr_done1", DW'(done1), 1);
    check("wr_done0", DW'(done0), 0);
    check("wr_rdata_keep", rdata, RdLine);
    req1 = 0; we1 = 0;
    tick();
    check("wr_done_pulse", DW'(done1), 0);

    // Contention after reset: grants alternate starting with requester 0.
    do_reset(1);
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = WrLine;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check("ct_grant", DW'(grant), DW'(exp_g));
      xact(2, RdLine2, rc, wc);
      check("ct_done", DW'({done1, done0}), DW'(exp_g));
      check("ct_resp_en", DW'({mem_read, mem_write}), '0);
      tick();
      check("ct_idle_grant", DW'(grant), '0);
    end
    req0 = 0; req1 = 0; we1 = 0;
    tick();

    // Requester drops its request during BUSY.
    req0 = 1; we0 = 0; addr0 = 32'h100;
    tick();
    check("dr_addr1", DW'(mem_address), DW'(32'h100));
    tick();
    req0 = 0; addr0 = 32'hDEAD;
    check("dr_addr2", DW'(mem_address), DW'(32'h100));
    xact(2, RdLine2, rc, wc);
    check("dr_done0", DW'(done0), 1);
    check("dr_rdata", rdata, RdLine2);
    check("dr_addr3", DW'(mem_address), DW'(32'h100));
    tick();

    // Reset mid-transaction, with mem_done colliding; then a tie must go to requester 0.
    req1 = 1; we1 = 0; addr1 = 32'h200;
    tick();
    check("mr_grant", DW'(grant), DW'(2'b10));
    req1 = 0;
    tick();
    reset = 1; mem_done = 1; mem_read_data = WrLine;
    tick();
    reset = 0; mem_done = 0;
    check("mr_done", DW'({done1, done0}), '0);
    check("mr_grant0", DW'(grant), '0);
    check("mr_en", DW'({mem_read, mem_write}), '0);
    check("mr_busy", DW'(busy), 0);
    check("mr_rdata", rdata, '0);
    check("mr_addr", DW'(mem_address), '0);
    req0 = 1; we0 = 0; addr0 = 32'h300; req1 = 1; we1 = 0; addr1 = 32'h400;
    tick();
    check("mr_tie", DW'(grant), DW'(2'b01));
    req0 = 0; req1 = 0;
    xact(1, RdLine, rc, wc);
    check("mr_tie_done", DW'(done0), 1);
    tick();

    // Memory never answers.
    req0 = 1; we0 = 0; addr0 = 32'h500;
    tick();
    req0 = 0;
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (mem_read && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles", DW'(n), 8);
    check("to_done0", DW'(done0), 1);
    check("to_err", DW'(err), 1);
    check("to_rdata", rdata, RdLine);
    tick();
    tick();
    check("to_err_sticky", DW'(err), 1);
    check("to_idle", DW'(busy), 0);
    do_reset(1);
    check("to_err_rst", DW'(err), 0);
`else
    n = 0;
    repeat (30) begin
      if (busy && mem_read && !done0) n++;
      tick();
    end
    check("nt_busy_cycles", DW'(n), 30);
    check("nt_err", DW'(err), 0);
    do_reset(1);
    check("nt_rst_busy", DW'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 128-bit, line-wide data memory, which uses a read/write-enable plus `done` handshake.
- Requester 0 is the multicycle core's load/store path; requester 1 is the crypto engine's line-transfer port.
- The arbiter selects one requester, latches its command, and holds the memory enables until the memory's `done`.
- It then returns the line and a one-cycle `done` to the winning requester, using round-robin fairness.

Parameters:
- AW, 32, address width in bits.
- DW, 128, data line width in bits.
- TIMEOUT, 64, maximum BUSY cycles before abort. Used only when ARB_TIMEOUT_EN is defined. Legal range is 2 to 2^16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 command valid.
- we0  in  1  requester 0 command type: 1 = write, 0 = read.
- addr0  in  AW  requester 0 byte address.
- wdata0  in  DW  requester 0 write line.
- req1  in  1  requester 1 command valid.
- we1  in  1  requester 1 command type: 1 = write, 0 = read.
- addr1  in  AW  requester 1 byte address.
- wdata1  in  DW  requester 1 write line.
- done0  out  1  one-cycle completion pulse to requester 0.
- done1  out  1  one-cycle completion pulse to requester 1.
- rdata  out  DW  returned line; valid in the `done*` cycle and held until the next completion.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- busy  out  1  high in BUSY and RESP.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_address  out  AW  memory address.
- mem_write_data  out  DW  memory write line.
- mem_read_data  in  DW  memory read line.
- mem_done  in  1  memory completion.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: the following are all 0.
  - state=IDLE
  - mem_read, mem_write, mem_address, mem_write_data
  - done0/1, grant, busy, rdata, err
- Reset also sets last_grant=1, so requester 0 wins the first tie.
- Reset applies immediately, including mid-transaction. The aborted transaction gets no `done`.
- All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both req high: grant the requester not equal to last_grant.
  - On grant:
    - Latch we, addr and wdata of the winner.
    - Set grant one-hot and busy=1, then go to BUSY.
    - In the same edge, drive mem_read=~we and mem_write=we, so the enables are high from the first BUSY cycle.
- BUSY:
  - Hold the enables, mem_address and mem_write_data constant.
  - Ignore req0 and req1 entirely; dropping or changing them does not affect the transaction.
  - On mem_done=1:
    - rdata <= mem_read_data for a read; rdata is unchanged for a write.
    - Clear both enables.
    - Set done of the owner to 1 and update last_grant to the owner.
    - Go to RESP.
- RESP (exactly one cycle):
  - done pulse is high and grant is still the owner.
  - Next edge: done=0, grant=00, busy=0, state=IDLE.
- Latency: req sampled at edge N → enables high after N. With mem_done seen at edge N+k (k≥1), `done` is high in the cycle after N+k. Minimum turnaround, req to done, is 2 edges. A new grant is made no earlier than the edge after RESP.
- Requester protocol:
  - Hold req and the command stable until the first BUSY edge.
  - Deassert req in the done cycle, or it is re-arbitrated as a new request.
  - When req is held continuously by both requesters, grants alternate 0, 1, 0, 1 …
- Address is passed through unmodified. Word selection within the line stays with the requester.
- mem_done outside BUSY is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches TIMEOUT-1 without mem_done: clear the enables, set err=1 (sticky until reset), leave rdata unchanged, and proceed to RESP as a normal completion, so the owner is never deadlocked.
  - mem_done and the timeout on the same edge: mem_done wins and err is not set.
- When undefined: BUSY waits indefinitely, no counter is instantiated, and err is tied 0.

Test Plan:
- Reset then read: reset=1 for 2 cycles, then req0=1, we0=0, addr0=0x40, memory returns 0x0123…CDEF with mem_done after 3 cycles → mem_read high for exactly 3 cycles with mem_address=0x40; done0 is a single pulse; rdata=0x0123…CDEF; grant returns to 00.
- Write: req1=1, we1=1, addr1=0x80, wdata1=128'hA5…A5 → mem_write=1, mem_write_data=A5…A5, mem_read=0 throughout; done1 pulses once; rdata is unchanged.
- Contention: req0 and req1 both held high for 4 transactions after reset → grant sequence 01, 10, 01, 10; there is never more than one enable high, and enables are never high in RESP.
- Request drop: req0 deasserted on the second BUSY cycle → the transaction completes, done0 still pulses, and mem_address is stable throughout.
- Mid-operation reset: reset=1 while in BUSY → the next cycle has all outputs 0, no done pulse, and the first subsequent tie is won by requester 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): mem_done never asserted → enables drop after 8 BUSY cycles, done0 pulses, err=1 and stays 1 until reset. Without the macro, busy stays 1 indefinitely and err=0.
